nibble_unpacker: RTL
====================

// Module: nibble_unpacker
// PURPOSE
//  Reader side of the nibble-wise 12-bit word store: fetches 12-bit words from a
//  synchronous RAM and streams each word out as three 4-bit nibbles with valid/ready.
//  Nibble select uses the store's write encoding (00=[3:0], 01=[7:4], 10=[11:8]).
//  Sits between the game RAM and nibble-wide consumers (colour/sprite pipelines).
// PARAMETERS
//  ADDR_W  10  RAM address width
//  CNT_W   10  width of word_count (max words per burst = 2**CNT_W-1)
// PORTS
//  Clk          in   1       system clock, rising edge
//  Reset        in   1       asynchronous, active-low reset
//  start        in   1       burst request; sampled only in IDLE
//  base_addr    in   ADDR_W  first word address, latched on accepted start
//  word_count   in   CNT_W   words in burst, latched on accepted start
//  mem_rd_en    out  1       RAM read strobe
//  mem_addr     out  ADDR_W  RAM read address
//  mem_rd_data  in   12      RAM data, valid 1 cycle after mem_rd_en
//  nib_valid    out  1       nib_data/nib_sel valid
//  nib_ready    in   1       consumer accepts nibble when nib_valid & nib_ready
//  nib_data     out  4       current nibble
//  nib_sel      out  2       nibble index (00/01/10); 11 never driven
//  nib_last     out  1       high with the final nibble of the burst
//  busy         out  1       high in any state other than IDLE
//  done         out  1       one-cycle pulse at burst completion
// BEHAVIOUR
//  Reset (Reset=0, async): state=IDLE; all outputs 0; addr/count/holding regs 0.
//  FSM: IDLE -> REQ -> WAIT -> SEND -> (REQ | FIN) ; FIN -> IDLE.
//   IDLE: start=1 latches base_addr/word_count; count=0 -> FIN, else -> REQ.
//   REQ : mem_rd_en=1, mem_addr=current addr, one cycle -> WAIT.
//   WAIT: capture mem_rd_data into 12-bit holding reg at end of cycle -> SEND, idx=00.
//   SEND: nib_valid=1, nib_data=hold[4*idx+3:4*idx], nib_sel=idx. On handshake:
//         idx 00->01->10; on idx=10 handshake: addr+1, remaining-1;
//         remaining becomes 0 -> FIN, else -> REQ.
//   FIN : done=1 for exactly one cycle -> IDLE.
//  Latency: start sampled at edge N -> mem_rd_en in cycle N+1 -> first nib_valid in
//   cycle N+3. Per word, with nib_ready held high: 5 cycles (REQ, WAIT, 3x SEND).
//  Hold rule: while nib_valid & !nib_ready, nib_data/nib_sel/nib_last stay constant.
//  nib_last = nib_valid & idx=10 & remaining=1.
//  Address wraps modulo 2**ADDR_W (0x3FF+1 -> 0x000); no error flag.
//  start while busy: ignored (not queued). start in FIN cycle: ignored.
//  word_count=0: no RAM reads, no nibbles; done pulses in cycle N+1.
//  mem_rd_en is high only in REQ; mem_addr holds last value otherwise.
//  Reset asserted mid-burst: immediate abort to IDLE, no done pulse.
// CONFIGURATION
//  NIBBLE_MSB_FIRST_EN defined: order per word is idx 10,01,00 ([11:8] first);
//   nib_last then accompanies idx 00 of final word; nib_sel still reports true index.
//  Not defined (default): order 00,01,10 ([3:0] first) as above.
// TESTING
//  1 Reset low mid-SEND -> all outputs 0 same cycle, state IDLE, no done after release.
//  2 base=0x010,count=2, RAM[0x010]=0xABC,[0x011]=0x123, ready=1 -> nibbles
//    C/00,B/01,A/10,3/00,2/01,1/10; nib_last on 1; done 1 cycle after; 10 cycles total.
//  3 count=1, RAM=0x5A3, ready toggles 1,0,0,1,... -> each nibble held stable while
//    ready=0; sequence 3,A,5 with no duplicates or drops.
//  4 count=0 -> no mem_rd_en, no nib_valid, done pulse in cycle N+1.
//  5 base=0x3FF,count=2 -> mem_addr 0x3FF then 0x000; start pulses during busy ignored.
//  6 NIBBLE_MSB_FIRST_EN, RAM=0xABC,count=1 -> A/10,B/01,C/00, nib_last on C.

Source files
------------

// File: rtl/nibble_unpacker.sv
// Streams 12-bit RAM words out as three 4-bit nibbles with valid/ready handshaking.
// Optional build macro NIBBLE_MSB_FIRST_EN emits [11:8] first instead of [3:0].
module nibble_unpacker #(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 10
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  word_count,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [11:0]       mem_rd_data,
    output logic              nib_valid,
    input  logic              nib_ready,
    output logic [3:0]        nib_data,
    output logic [1:0]        nib_sel,
    output logic              nib_last,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_SEND, S_FIN} state_t;

`ifdef NIBBLE_MSB_FIRST_EN
    localparam logic [1:0] IDX_FIRST = 2'b10;
    localparam logic [1:0] IDX_LAST  = 2'b00;
`else
    localparam logic [1:0] IDX_FIRST = 2'b00;
    localparam logic [1:0] IDX_LAST  = 2'b10;
`endif

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic [11:0]       hold_q, hold_d;
    logic [1:0]        idx_q, idx_d;
    logic              word_end;

    function automatic logic [1:0] step_idx(input logic [1:0] idx);
`ifdef NIBBLE_MSB_FIRST_EN
        return idx - 2'd1;
`else
        return idx + 2'd1;
`endif
    endfunction

    function automatic logic [3:0] pick_nibble(input logic [11:0] w, input logic [1:0] idx);
        case (idx)
            2'b00:   return w[3:0];
            2'b01:   return w[7:4];
            default: return w[11:8];
        endcase
    endfunction

    assign word_end = (state_q == S_SEND) && nib_ready && (idx_q == IDX_LAST);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            mem_addr_q <= '0;
            rem_q      <= '0;
            hold_q     <= '0;
            idx_q      <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            mem_addr_q <= mem_addr_d;
            rem_q      <= rem_d;
            hold_q     <= hold_d;
            idx_q      <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = (word_count == '0) ? S_FIN : S_REQ;
            S_REQ:  state_d = S_WAIT;
            S_WAIT: state_d = S_SEND;
            S_SEND: if (word_end) state_d = (rem_q == CNT_W'(1)) ? S_FIN : S_REQ;
            S_FIN:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        addr_d = addr_q;
        rem_d  = rem_q;
        hold_d = hold_q;
        idx_d  = idx_q;
        if (state_q == S_IDLE && start) begin
            addr_d = base_addr;
            rem_d  = word_count;
        end
        if (state_q == S_WAIT) begin
            hold_d = mem_rd_data;
            idx_d  = IDX_FIRST;
        end
        if (state_q == S_SEND && nib_ready) begin
            if (idx_q == IDX_LAST) begin
                addr_d = addr_q + ADDR_W'(1);
                rem_d  = rem_q - CNT_W'(1);
            end else begin
                idx_d = step_idx(idx_q);
            end
        end
        // mem_addr only moves when a read is about to be issued, so it holds between reads
        mem_addr_d = (state_d == S_REQ) ? addr_d : mem_addr_q;
    end

    always_comb begin
        mem_rd_en = (state_q == S_REQ);
        nib_valid = (state_q == S_SEND);
        nib_sel   = (state_q == S_SEND) ? idx_q : 2'b00;
        nib_data  = (state_q == S_SEND) ? pick_nibble(hold_q, idx_q) : 4'h0;
        nib_last  = (state_q == S_SEND) && (idx_q == IDX_LAST) && (rem_q == CNT_W'(1));
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_FIN);
    end

    assign mem_addr = mem_addr_q;

endmodule
